approx_multiplier_4x4: RTL and testbench



---
 rtl/approx_multiplier_4x4_pkg.sv | 10 +
 rtl/fa_cell.sv | 11 +
 rtl/approx_multiplier_4x4.sv | 92 +++++++++
 tb/tb_approx_multiplier_4x4.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/approx_multiplier_4x4_pkg.sv
// Shared widths and parameter legality helper for the 4x4 approximate multiplier.
package approx_multiplier_4x4_pkg;
    localparam int OPERAND_W       = 4;
    localparam int PRODUCT_W       = 8;
    localparam int APPROX_COLS_MAX = 4;

    function automatic bit approx_cols_legal(input int cols);
        return (cols >= 0) && (cols <= APPROX_COLS_MAX);
    endfunction
endpackage

// File: rtl/fa_cell.sv
// One-bit full adder used as the carry-save and ripple building block.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/approx_multiplier_4x4.sv
// Unsigned 4x4 multiplier: low columns OR-reduced without carries, high columns summed
// exactly by a carry-save tree and a ripple adder; registered copy of the product.
module approx_multiplier_4x4
    import approx_multiplier_4x4_pkg::*;
#(
    parameter int APPROX_COLS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] A,
    input  logic [OPERAND_W-1:0] B,
    output logic [PRODUCT_W-1:0] result,
    output logic [PRODUCT_W-1:0] result_q
);
    if (!approx_cols_legal(APPROX_COLS)) begin : g_bad_param
        $error("approx_multiplier_4x4: APPROX_COLS out of range 0..4");
    end

    logic [OPERAND_W-1:0][OPERAND_W-1:0] pp;
    logic [OPERAND_W-1:0][OPERAND_W-1:0] ppe;
    logic [PRODUCT_W-1:0] rows [OPERAND_W];
    logic [PRODUCT_W-1:0] l_bits;
    logic [PRODUCT_W-1:0] s1, s2, h_sum, rc;
    logic [PRODUCT_W-2:0] c1, c2;
    logic [PRODUCT_W-1:0] c1_sh, c2_sh;

    // Partial products; ppe keeps only those belonging to the exact columns.
    for (genvar gi = 0; gi < OPERAND_W; gi++) begin : g_pp_row
        for (genvar gj = 0; gj < OPERAND_W; gj++) begin : g_pp_col
            assign pp[gi][gj] = B[gi] & A[gj];
            if (gi + gj >= APPROX_COLS) begin : g_exact
                assign ppe[gi][gj] = pp[gi][gj];
            end else begin : g_approx
                assign ppe[gi][gj] = 1'b0;
            end
        end
        assign rows[gi] = PRODUCT_W'(ppe[gi]) << gi;
    end

    for (genvar gc = 0; gc < PRODUCT_W; gc++) begin : g_col_or
        if (gc < APPROX_COLS) begin : g_or
            logic [OPERAND_W-1:0] terms;
            for (genvar gi = 0; gi < OPERAND_W; gi++) begin : g_term
                if ((gc >= gi) && (gc - gi < OPERAND_W)) begin : g_hit
                    assign terms[gi] = pp[gi][gc-gi];
                end else begin : g_miss
                    assign terms[gi] = 1'b0;
                end
            end
            assign l_bits[gc] = |terms;
        end else begin : g_zero
            assign l_bits[gc] = 1'b0;
        end
    end

    assign c1_sh = {c1, 1'b0};
    assign c2_sh = {c2, 1'b0};
    assign rc[0] = 1'b0;

    // The product never exceeds 225, so carries out of the top bit are simply not formed.
    for (genvar gi = 0; gi < PRODUCT_W; gi++) begin : g_tree
        if (gi < PRODUCT_W - 1) begin : g_fa
            fa_cell u_csa1 (
                .a(rows[0][gi]), .b(rows[1][gi]), .cin(rows[2][gi]),
                .sum(s1[gi]), .cout(c1[gi])
            );
            fa_cell u_csa2 (
                .a(s1[gi]), .b(c1_sh[gi]), .cin(rows[3][gi]),
                .sum(s2[gi]), .cout(c2[gi])
            );
            fa_cell u_rip (
                .a(s2[gi]), .b(c2_sh[gi]), .cin(rc[gi]),
                .sum(h_sum[gi]), .cout(rc[gi+1])
            );
        end else begin : g_msb
            assign s1[gi]    = rows[0][gi] ^ rows[1][gi] ^ rows[2][gi];
            assign s2[gi]    = s1[gi] ^ c1_sh[gi] ^ rows[3][gi];
            assign h_sum[gi] = s2[gi] ^ c2_sh[gi] ^ rc[gi];
        end
    end

    // H has no bits set below APPROX_COLS, so OR merges the two parts without an adder.
    assign result = h_sum | l_bits;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result;
        end
    end
endmodule

// File: tb/tb_approx_multiplier_4x4.sv
// Bench for approx_multiplier_4x4: spot table, exhaustive sweeps (default and exact builds)
// and register/asynchronous-reset sequences.
module tb_approx_multiplier_4x4;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic [7:0] result, result_q, result0, result_q0;

    int tests = 0;
    int fails = 0;

    approx_multiplier_4x4 dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .result(result), .result_q(result_q)
    );

    approx_multiplier_4x4 #(.APPROX_COLS(0)) dut_exact (
        .clk(clk), .rst(rst), .A(a), .B(b), .result(result0), .result_q(result_q0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] expected;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [7:0] golden(input logic [3:0] x, input logic [3:0] y, input int cols);
        int h;
        logic [7:0] l;
        int cnt;
        h = 0;
        l = 8'd0;
        for (int c = 0; c < 7; c++) begin
            cnt = 0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (i + j == c && y[i] && x[j]) cnt++;
            if (c < cols) l[c] = (cnt != 0);
            else h += cnt << c;
        end
        return 8'(h + int'(l));
    endfunction

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    initial begin
        real err_sum;
        int  nz;
        int  sweep_bad, bound_bad, exact_bad;

        vecs[0] = '{4'd3,  4'd3,  8'd7};
        vecs[1] = '{4'd15, 4'd15, 8'd215};
        vecs[2] = '{4'd5,  4'd6,  8'd30};
        vecs[3] = '{4'd3,  4'd5,  8'd15};
        vecs[4] = '{4'd15, 4'd1,  8'd15};
        vecs[5] = '{4'd0,  4'd9,  8'd0};
        vecs[6] = '{4'd9,  4'd0,  8'd0};
        vecs[7] = '{4'd1,  4'd1,  8'd1};

        // Reset state
        #2;
        check("reset result_q", result_q, 8'd0);
        check("reset result_q exact", result_q0, 8'd0);

        foreach (vecs[k]) begin
            a = vecs[k].a;
            b = vecs[k].b;
            #1;
            check($sformatf("spot %0dx%0d", vecs[k].a, vecs[k].b), result, vecs[k].expected);
        end

        // Exhaustive sweeps; one comparison line per pair only on failure, to keep output short
        err_sum = 0.0;
        nz = 0;
        sweep_bad = 0;
        bound_bad = 0;
        exact_bad = 0;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                a = 4'(x);
                b = 4'(y);
                #1;
                tests += 3;
                if (result !== golden(a, b, 3)) begin
                    fails++; sweep_bad++;
                    $display("FAIL sweep %0dx%0d: got %0d, expected %0d", x, y, result, golden(a, b, 3));
                end
                if (!(int'(result) <= x * y)) begin
                    fails++; bound_bad++;
                    $display("FAIL bound %0dx%0d: got %0d, expected <= %0d", x, y, result, x * y);
                end
                if (result0 !== 8'(x * y)) begin
                    fails++; exact_bad++;
                    $display("FAIL exact %0dx%0d: got %0d, expected %0d", x, y, result0, x * y);
                end
                if (x * y != 0) begin
                    err_sum += real'(x * y - int'(result)) / real'(x * y);
                    nz++;
                end
            end
        end
        $display("sweep: %0d golden errors, %0d bound errors, %0d exact-build errors", sweep_bad, bound_bad, exact_bad);
        $display("mean relative error over %0d nonzero products: %f", nz, err_sum / real'(nz));

        // Register path
        @(negedge clk);
        rst = 1'b1;
        a = 4'd15;
        b = 4'd15;
        @(negedge clk);
        check("rst held result_q", result_q, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("result_q 15x15", result_q, 8'd215);
        check("result_q exact 15x15", result_q0, 8'd225);
        a = 4'd3;
        b = 4'd3;
        #1;
        check("result_q before edge", result_q, 8'd215);
        @(negedge clk);
        check("result_q 3x3", result_q, 8'd7);

        // Asynchronous reset between edges
        a = 4'd15;
        b = 4'd15;
        @(negedge clk);
        check("result_q reload 215", result_q, 8'd215);
        #2;
        rst = 1'b1;
        #1;
        check("async rst result_q", result_q, 8'd0);
        check("rst leaves result", result, 8'd215);
        @(negedge clk);
        check("rst edge1 result_q", result_q, 8'd0);
        @(negedge clk);
        check("rst edge2 result_q", result_q, 8'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post-rst result_q", result_q, 8'd215);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
